dmem_responder: RTL and testbench
=================================

# dmem_responder

Data-memory responder for the single-cycle CPU's DM port. It serves combinational word reads and clocked word writes from an on-chip RAM. It also exposes a small memory-mapped I/O window: a transmit FIFO, a status word and a cycle counter. After reset it zeroes the RAM with a clear sequencer, holding `busy` high while it runs, so the top level can stall the CPU through `ena`.

## Interface
Parameters:
- `ADDR_W`, 11, width of the word address; total space is 2^ADDR_W words.
- `TX_DEPTH`, 4, transmit FIFO depth; must be a power of two, at least 2.
- `CLEAR_ON_RESET`, 1, selects whether a clear pass runs after reset (1) or is skipped (0).

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `DM_W` in 1: write strobe.
- `DM_R` in 1: read strobe.
- `DM_addr` in ADDR_W: word address.
- `DM_wdata` in 32: write data.
- `DM_rdata` out 32: read data, combinational.
- `busy` out 1: clear pass in progress; all accesses are ignored while high.
- `tx_data` out 32: FIFO head word.
- `tx_valid` out 1: FIFO not empty.
- `tx_ready` in 1: consumer accepts the head word this cycle.

## Operation
Address map, word addresses, with `TOP` = 2^ADDR_W − 1:
- 0 .. `TOP`−4: RAM, 2^ADDR_W − 4 words.
- `TOP`−3, TX_DATA:
  - Write pushes `DM_wdata`.
  - Read returns the head word, or 0 when the FIFO is empty. A read never pops.
- `TOP`−2, STATUS, read-only:
  - bits [7:0] = FIFO count.
  - bit 8 = empty.
  - bit 9 = full.
  - bit 10 = overflow (sticky).
  - all other bits = 0.
- `TOP`−1, CYCLE:
  - Read returns the 32-bit counter.
  - Write loads it with `DM_wdata`.
- `TOP`, CTRL:
  - Reads return 0.
  - A write with `DM_wdata[0]`=1 clears overflow.
  - A write with `DM_wdata[1]`=1 flushes the FIFO.

FSM:
- States are CLEAR and RUN.
- While `rst` is high: state = CLEAR, or RUN if `CLEAR_ON_RESET`=0. Also clear_ptr=0, FIFO empty, overflow=0, counter=0.
- In CLEAR, each cycle:
  - write 0 to RAM[clear_ptr];
  - clear_ptr increments;
  - after the write at `TOP`−4, the next state is RUN.
- `busy` = (state == CLEAR).

RAM and FIFO rules:
- `DM_rdata` = 0 when `DM_R`=0 or `busy`=1.
- When `DM_R` and `DM_W` are both asserted to the same address, `DM_rdata` shows the pre-write value and the write commits at the edge.
- A push is accepted if the FIFO is not full, or if a pop happens in the same cycle.
- A rejected push drops the data and sets overflow.
- A pop occurs when `tx_valid && tx_ready`.
- Flush takes priority over a same-cycle push or pop. The FIFO ends empty and the push is discarded, with no overflow.
- A same-cycle CTRL write setting overflow-clear and an overflow event cannot coincide: they are different addresses, and the CPU issues one access per cycle.

Cycle counter:
- Holds 0 in CLEAR.
- In RUN it increments by 1 each cycle and wraps from 0xFFFFFFFF to 0.
- A CYCLE write loads the written value; the next cycle shows that value, with no increment in the load cycle.

## Timing
- Read latency is 0 cycles: `DM_rdata` is a combinational function of `DM_addr`, `DM_R`, RAM contents, FIFO and counter state.
- Writes, pushes and loads commit on the rising `clk` edge where the strobe is high.
- Clear pass lasts exactly 2^ADDR_W − 4 cycles after the first edge with `rst` low; `busy` falls in the cycle after the last clear write.
- Outputs during and right after reset:
  - `busy`=`CLEAR_ON_RESET`;
  - `tx_valid`=0;
  - `tx_data`=0;
  - `DM_rdata`=0.
- `tx_data` is 0 whenever the FIFO is empty.
- `tx_valid`/`tx_data` change only on clock edges. The consumer may hold `tx_ready` high indefinitely; one word pops per cycle.
- Reset asserted mid-clear or mid-run restarts the clear pass. RAM contents written before that point are then undefined until the pass completes.

## Structure
- Package `dmem_pkg` holds:
  - the state enum (CLEAR/RUN);
  - MMIO offsets from `TOP` (TX_DATA=3, STATUS=2, CYCLE=1, CTRL=0);
  - STATUS bit positions;
  - CTRL bit positions.
- Sub-module `tx_fifo` is a synchronous FIFO parameterised by depth and width. Its ports are push, pop, flush, full, empty, count and head.
- The top level contains the RAM array, address decode, clear FSM, counter and overflow flag.

## Test plan
- Reset with ADDR_W=6, then release → `busy` high for exactly 60 cycles, then low; reading any RAM word returns 0.
- Write 0xDEADBEEF to word 5 with `DM_R` held on the same address → `DM_rdata` is the old value (0) in that cycle and 0xDEADBEEF in the next.
- With `tx_ready`=0, push 5 words to TX_DATA at depth 4 → count=4, full=1, overflow=1, head = first word. Then hold `tx_ready`=1 → 4 words drain in order, one per cycle, and `tx_valid` falls.
- With the FIFO full, push and pop in the same cycle → push accepted, count stays 4, overflow unchanged. A CTRL write of 0x3 → FIFO empty, overflow=0.
- Write 0xFFFFFFFE to CYCLE → the following reads return 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000.
- Assert `rst` for one cycle midway through the clear pass, and issue `DM_W` while `busy` → clear pass restarts from 0, and the write is ignored.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: controller states,
// MMIO window offsets (measured down from the top word address) and the
// bit layout of the STATUS and CTRL registers.
package dmem_pkg;

    // Controller states: CLEAR zeroes the RAM after reset, RUN serves the CPU.
    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } dmem_state_e;

    // MMIO register offsets below TOP = 2^ADDR_W - 1.
    localparam int OFS_TX_DATA = 3;
    localparam int OFS_STATUS  = 2;
    localparam int OFS_CYCLE   = 1;
    localparam int OFS_CTRL    = 0;

    // Number of MMIO words carved out of the top of the address space.
    localparam int MMIO_WORDS  = 4;

    // STATUS register layout.
    localparam int STAT_COUNT_LSB = 0;
    localparam int STAT_COUNT_W   = 8;
    localparam int STAT_EMPTY_BIT = 8;
    localparam int STAT_FULL_BIT  = 9;
    localparam int STAT_OVF_BIT   = 10;

    // CTRL register layout (write-only action bits).
    localparam int CTRL_OVF_CLR_BIT = 0;
    localparam int CTRL_FLUSH_BIT   = 1;

    // Assemble the STATUS word; every bit not named here reads as zero.
    function automatic logic [31:0] pack_status(
        input logic [STAT_COUNT_W-1:0] count,
        input logic                    empty,
        input logic                    full,
        input logic                    ovf
    );
        logic [31:0] s;
        s = '0;
        s[STAT_COUNT_LSB +: STAT_COUNT_W] = count;
        s[STAT_EMPTY_BIT]                 = empty;
        s[STAT_FULL_BIT]                  = full;
        s[STAT_OVF_BIT]                   = ovf;
        return s;
    endfunction

endpackage

// File: rtl/tx_fifo.sv
// Synchronous FIFO for the transmit path. DEPTH must be a power of two so
// the read and write pointers wrap naturally. The head word is driven to
// zero while the FIFO is empty, so it only ever changes on a clock edge.
// A push is accepted when the FIFO has room or when a pop frees a slot in
// the same cycle; flush wins over both and leaves the FIFO empty.
module tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic [WIDTH-1:0]         head
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty && !flush;
    assign do_push = push && (!full || do_pop) && !flush;
    assign head    = empty ? '0 : mem[rd_ptr];

    // Pointer and occupancy bookkeeping; reset and flush both empty the FIFO.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage write; no reset needed since empty slots are never observed.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the single-cycle CPU's DM port.
// Word-addressed RAM occupies the bottom of the address space; the top four
// words are an MMIO window (TX_DATA, STATUS, CYCLE, CTRL). After reset the
// controller zeroes the RAM one word per cycle with busy high, during which
// every CPU access is ignored and reads return zero.
//
// Transmit handshake: tx_valid is high whenever the FIFO holds a word and
// tx_data is that head word (zero when empty). A word is transferred on a
// rising edge where tx_valid && tx_ready; the consumer may hold tx_ready
// high indefinitely and one word is taken per cycle. tx_valid/tx_data only
// change on clock edges and tx_valid never depends on tx_ready.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_W         = 11,
    parameter int TX_DEPTH       = 4,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              DM_W,
    input  logic              DM_R,
    input  logic [ADDR_W-1:0] DM_addr,
    input  logic [31:0]       DM_wdata,
    output logic [31:0]       DM_rdata,
    output logic              busy,
    output logic [31:0]       tx_data,
    output logic              tx_valid,
    input  logic              tx_ready
);

    localparam int TOP       = (1 << ADDR_W) - 1;
    localparam int RAM_WORDS = TOP + 1 - MMIO_WORDS;
    localparam int CNT_W     = $clog2(TX_DEPTH) + 1;

    localparam logic [ADDR_W-1:0] LAST_RAM  = ADDR_W'(RAM_WORDS - 1);
    localparam logic [ADDR_W-1:0] A_TX_DATA = ADDR_W'(TOP - OFS_TX_DATA);
    localparam logic [ADDR_W-1:0] A_STATUS  = ADDR_W'(TOP - OFS_STATUS);
    localparam logic [ADDR_W-1:0] A_CYCLE   = ADDR_W'(TOP - OFS_CYCLE);
    localparam logic [ADDR_W-1:0] A_CTRL    = ADDR_W'(TOP - OFS_CTRL);

    // Controller state and clear sequencer.
    dmem_state_e       state;
    logic [ADDR_W-1:0] clear_ptr;

    // RAM storage.
    logic [31:0] ram [RAM_WORDS];

    // MMIO state.
    logic [31:0] cycle_cnt;
    logic        overflow;

    // Address decode and access qualifiers.
    logic acc_we;
    logic is_ram;
    logic ram_we;
    logic tx_push;
    logic cyc_load;
    logic ctrl_we;
    logic ovf_clr;
    logic fifo_flush;
    logic tx_pop;
    logic push_reject;

    // FIFO view.
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic [31:0]      fifo_head;
    logic [7:0]       status_count;
    logic [31:0]      status_word;

    assign busy = (state == ST_CLEAR);

    // CPU writes only take effect in RUN and outside reset.
    assign acc_we     = DM_W && !busy && !rst;
    assign is_ram     = (DM_addr <= LAST_RAM);
    assign ram_we     = acc_we && is_ram;
    assign tx_push    = acc_we && (DM_addr == A_TX_DATA);
    assign cyc_load   = acc_we && (DM_addr == A_CYCLE);
    assign ctrl_we    = acc_we && (DM_addr == A_CTRL);
    assign ovf_clr    = ctrl_we && DM_wdata[CTRL_OVF_CLR_BIT];
    assign fifo_flush = ctrl_we && DM_wdata[CTRL_FLUSH_BIT];

    assign tx_valid = !fifo_empty;
    assign tx_data  = fifo_head;
    assign tx_pop   = tx_valid && tx_ready;

    // A push into a full FIFO is dropped unless a same-cycle pop makes room;
    // a flush discards the push without flagging it.
    assign push_reject = tx_push && fifo_full && !tx_pop && !fifo_flush;

    assign status_count = 8'(fifo_count);
    assign status_word  = pack_status(status_count, fifo_empty, fifo_full, overflow);

    tx_fifo #(
        .DEPTH (TX_DEPTH),
        .WIDTH (32)
    ) u_tx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (tx_push),
        .push_data (DM_wdata),
        .pop       (tx_pop),
        .flush     (fifo_flush),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count),
        .head      (fifo_head)
    );

    // Clear/run controller: walk clear_ptr over every RAM word, then serve.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
            clear_ptr <= '0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    clear_ptr <= clear_ptr + 1'b1;
                    if (clear_ptr == LAST_RAM) begin
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    state <= ST_RUN;
                end
                default: begin
                    state <= ST_CLEAR;
                end
            endcase
        end
    end

    // RAM write port, shared between the clear sequencer and the CPU.
    always_ff @(posedge clk) begin
        if (!rst && (state == ST_CLEAR)) begin
            ram[clear_ptr] <= '0;
        end else if (ram_we) begin
            ram[DM_addr] <= DM_wdata;
        end
    end

    // Free-running cycle counter: held at zero while clearing, loadable from
    // the CPU (the loaded value is not incremented in the load cycle).
    always_ff @(posedge clk) begin
        if (rst || (state == ST_CLEAR)) begin
            cycle_cnt <= '0;
        end else if (cyc_load) begin
            cycle_cnt <= DM_wdata;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
        end
    end

    // Sticky overflow flag, cleared only by reset or a CTRL write.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end else if (push_reject) begin
            overflow <= 1'b1;
        end
    end

    // Combinational read mux; reads see state before any same-cycle write.
    always_comb begin
        DM_rdata = '0;
        if (DM_R && !busy) begin
            if (is_ram) begin
                DM_rdata = ram[DM_addr];
            end else if (DM_addr == A_TX_DATA) begin
                DM_rdata = fifo_head;
            end else if (DM_addr == A_STATUS) begin
                DM_rdata = status_word;
            end else if (DM_addr == A_CYCLE) begin
                DM_rdata = cycle_cnt;
            end else begin
                DM_rdata = '0;
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder with ADDR_W=6 (60 RAM words,
// MMIO at 60..63) and a 4-deep transmit FIFO. A behavioural model (RAM
// array, word queue, flags, counter) predicts every output each cycle.
module tb_dmem_responder;

  localparam int AW    = 6;
  localparam int DEPTH = 4;
  localparam int RAMW  = 60;
  localparam int A_TX  = 60;
  localparam int A_ST  = 61;
  localparam int A_CY  = 62;
  localparam int A_CT  = 63;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          dm_w;
  logic          dm_r;
  logic [AW-1:0] dm_addr;
  logic [31:0]   dm_wdata;
  logic [31:0]   dm_rdata;
  logic          busy;
  logic [31:0]   tx_data;
  logic          tx_valid;
  logic          tx_ready;

  dmem_responder #(
    .ADDR_W         (AW),
    .TX_DEPTH       (DEPTH),
    .CLEAR_ON_RESET (1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .DM_W     (dm_w),
    .DM_R     (dm_r),
    .DM_addr  (dm_addr),
    .DM_wdata (dm_wdata),
    .DM_rdata (dm_rdata),
    .busy     (busy),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready)
  );

  // ---------------- scoreboard / model ----------------
  int    n_checks = 0;
  int    n_errors = 0;
  string phase    = "init";

  logic [31:0] ram_m [RAMW];
  logic [31:0] exp_q [$];
  bit          ovf_m;
  bit          busy_m;
  int          clear_left;
  logic [31:0] cnt_m;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s.%s: got %h expected %h", phase, tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_head();
    if (exp_q.size() == 0) return 32'd0;
    return exp_q[0];
  endfunction

  function automatic logic [31:0] model_rdata();
    int a;
    a = int'(dm_addr);
    if (!dm_r || busy_m) return 32'd0;
    if (a < RAMW) return ram_m[a];
    if (a == A_TX) return model_head();
    if (a == A_ST) begin
      return 32'(exp_q.size())
           + ((exp_q.size() == 0)     ? 32'd256  : 32'd0)
           + ((exp_q.size() == DEPTH) ? 32'd512  : 32'd0)
           + (ovf_m                   ? 32'd1024 : 32'd0);
    end
    if (a == A_CY) return cnt_m;
    return 32'd0;
  endfunction

  task automatic check_outputs();
    check_eq("busy",     {31'd0, busy},     {31'd0, busy_m});
    check_eq("tx_valid", {31'd0, tx_valid}, (exp_q.size() != 0) ? 32'd1 : 32'd0);
    check_eq("tx_data",  tx_data,           model_head());
    check_eq("rdata",    dm_rdata,          model_rdata());
  endtask

  // Advance the model across one rising edge using the inputs in force.
  task automatic model_edge();
    logic [31:0] cnt_next;
    int a;
    if (rst) begin
      busy_m     = 1'b1;
      clear_left = RAMW;
      exp_q.delete();
      ovf_m      = 1'b0;
      cnt_m      = 32'd0;
      return;
    end
    if (busy_m) begin
      clear_left--;
      if (clear_left == 0) begin
        busy_m = 1'b0;
        for (int i = 0; i < RAMW; i++) ram_m[i] = 32'd0;
      end
      cnt_m = 32'd0;
      return;
    end
    cnt_next = cnt_m + 32'd1;
    if (tx_ready && exp_q.size() != 0) void'(exp_q.pop_front());
    if (dm_w) begin
      a = int'(dm_addr);
      if (a < RAMW) ram_m[a] = dm_wdata;
      else if (a == A_TX) begin
        if (exp_q.size() < DEPTH) exp_q.push_back(dm_wdata);
        else ovf_m = 1'b1;
      end else if (a == A_CY) cnt_next = dm_wdata;
      else if (a == A_CT) begin
        if (dm_wdata[1]) exp_q.delete();
        if (dm_wdata[0]) ovf_m = 1'b0;
      end
    end
    cnt_m = cnt_next;
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive(input bit w, input bit r, input int addr, input logic [31:0] wd, input bit rdy);
    dm_w     = w;
    dm_r     = r;
    dm_addr  = AW'(addr);
    dm_wdata = wd;
    tx_ready = rdy;
    cycle();
  endtask

  // Run through a clear pass with random (ignored) traffic, counting busy cycles.
  task automatic wait_clear();
    int seen;
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      dm_w     = 1'($urandom_range(0, 1));
      dm_r     = 1'b1;
      dm_addr  = AW'($urandom_range(0, 63));
      dm_wdata = $urandom;
      tx_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      check_outputs();
      if (!busy) break;
      seen++;
      @(posedge clk);
      model_edge();
      #1;
    end
    check_eq("clear_len", 32'(seen), 32'd60);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic read_all_ram();
    for (int i = 0; i < RAMW; i++) drive(1'b0, 1'b1, i, 32'd0, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; dm_w = 1'b0; dm_r = 1'b0; dm_addr = '0; dm_wdata = '0; tx_ready = 1'b0;
    busy_m = 1'b1; clear_left = RAMW; cnt_m = 32'd0; ovf_m = 1'b0;
    @(posedge clk);
    model_edge();
    #1;

    phase = "reset";
    drive(1'b0, 1'b1, 3, 32'd0, 1'b1);
    drive(1'b1, 1'b1, A_ST, 32'h1234, 1'b1);

    phase = "clear";
    rst = 1'b0;
    wait_clear();
    read_all_ram();

    phase = "rw_same";
    drive(1'b1, 1'b1, 5, 32'hDEADBEEF, 1'b0);
    drive(1'b0, 1'b1, 5, 32'd0, 1'b0);

    phase = "tx_fill";
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, A_TX, $urandom, 1'b0);
    drive(1'b0, 1'b1, A_ST, 32'd0, 1'b0);
    drive(1'b0, 1'b1, A_TX, 32'd0, 1'b0);
    phase = "tx_drain";
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, A_ST, 32'd0, 1'b1);

    phase = "tx_full_pp";
    drive(1'b1, 1'b0, A_CT, 32'd1, 1'b0);
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, A_TX, $urandom, 1'b0);
    drive(1'b1, 1'b1, A_TX, 32'hCAFEF00D, 1'b1);
    drive(1'b0, 1'b1, A_ST, 32'd0, 1'b0);
    drive(1'b1, 1'b0, A_TX, 32'h5555AAAA, 1'b0);
    drive(1'b0, 1'b1, A_ST, 32'd0, 1'b0);
    drive(1'b1, 1'b1, A_CT, 32'd3, 1'b1);
    drive(1'b0, 1'b1, A_ST, 32'd0, 1'b0);

    phase = "cycle";
    drive(1'b1, 1'b1, A_CY, 32'hFFFFFFFE, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, A_CY, 32'd0, 1'b0);

    phase = "random";
    for (int i = 0; i < 800; i++) begin
      int a;
      logic [31:0] wd;
      a  = ($urandom_range(0, 1) == 1) ? $urandom_range(A_TX, A_CT) : $urandom_range(0, RAMW - 1);
      wd = $urandom;
      if (a == A_CT) wd = ($urandom_range(0, 3) == 0) ? 32'(wd[1:0]) : 32'(wd[0]);
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), a, wd,
            1'($urandom_range(0, 2) == 0));
    end

    phase = "mid_reset";
    rst = 1'b1;
    drive(1'b0, 1'b1, 0, 32'd0, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) drive(1'b1, 1'b1, 5, $urandom, 1'b1);
    rst = 1'b1;
    drive(1'b1, 1'b1, 5, 32'hBADC0DE5, 1'b0);
    rst = 1'b0;
    wait_clear();
    read_all_ram();
    drive(1'b0, 1'b1, A_ST, 32'd0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
